lgs_rr_ctrl: RTL and testbench
==============================

# lgs_rr_ctrl

Parametrised, clocked successor to the lgsynth91 request/override control cones. Handles NREQ request lines, NCH gated channel-status outputs and a global override, and adds state: a round-robin grant FSM, a grant hold counter and registered outputs. It sits between the request sources and the downstream channel logic. It replaces the flat combinational "no request pending" detect and the override-masked channel enables.

## Interface
Parameters:
- NREQ, 7: number of request lines. Range 2..32.
- NCH, 2: number of gated status channels. Range 1..8.
- HOLD_CYC, 16: grant timeout in cycles. Used only with the timeout feature. Range 2..2^16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  NREQ  request lines, level-sensitive; bit i is requester i.
- pass  in  1  arbitration enable; no new grant is issued while 0.
- ovr  in  1  global override: masks the channels, blocks grants and aborts the current grant.
- ack  in  1  grant completion from the granted requester; single-cycle pulse.
- ch_en  in  NCH  per-channel enable.
- src_a  in  1  status source A, shared by all channels.
- src_b  in  1  status source B, shared by all channels.
- gnt  out  NREQ  one-hot grant; all-zero when nothing is granted.
- gnt_vld  out  1  a grant is active (OR of gnt).
- idle  out  1  registered: req is all-zero and pass=1.
- ch_a  out  NCH  registered: ~ovr & ch_en[i] & src_a.
- ch_b  out  NCH  registered: ~ovr & ch_en[i] & src_b.
- to_flag  out  1  sticky timeout flag. Constant 0 when the timeout feature is compiled out.

## Operation
- Internal state:
  - FSM state: IDLE or GRANT.
  - Round-robin pointer ptr, $clog2(NREQ) bits.
  - Index gidx of the current grant.
  - Hold counter hcnt, $clog2(HOLD_CYC) bits.
- IDLE:
  - When pass=1, ovr=0 and |req=1: select the first set req bit scanning upward from ptr, wrapping NREQ-1 -> 0.
  - Load gidx with that bit, clear hcnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: gnt = onehot(gidx) and gnt_vld = 1. The exits below are listed in priority order.
  1. ovr=1: abort to IDLE, ptr unchanged.
  2. ack=1: complete to IDLE, ptr = (gidx+1) mod NREQ.
  3. req[gidx]=0 (withdrawn): go to IDLE, ptr unchanged.
  4. Timeout (feature only): hcnt == HOLD_CYC-1 with none of the above. Go to IDLE, ptr = (gidx+1) mod NREQ, set to_flag.
  5. Otherwise hcnt increments and saturates at HOLD_CYC-1.
- ack received in IDLE is ignored.
- ptr wrap-around: gidx = NREQ-1 completing gives ptr = 0.
- Simultaneous ovr, ack and timeout in the same cycle: ovr wins. ptr is unchanged and to_flag is not set.
- ch_a, ch_b and idle are registered every cycle, independent of FSM state.
- Reset values:
  - gnt=0, gnt_vld=0, idle=0, ch_a=0, ch_b=0, to_flag=0.
  - ptr=0, gidx=0, hcnt=0, state IDLE.
- A rst asserted mid-grant drops gnt on the next edge. No ack is required.

## Timing
- Grant latency: req/pass sampled at edge t in IDLE -> gnt valid after edge t+1.
- Release latency: ack high at edge t -> gnt=0 after edge t+1.
- Back-to-back grants: there is always at least one IDLE cycle between grants. Earliest next grant is after edge t+2.
- ovr abort latency: 1 cycle.
- Timeout: the grant ends after exactly HOLD_CYC cycles with gnt high, counting the first grant cycle.
- Channel latency: ch_a, ch_b and idle each lag their inputs by 1 cycle.
- No combinational path from any input to any output.

## Configuration
- LGS_RR_TIMEOUT_EN defined:
  - hcnt, the timeout exit and to_flag are present.
  - to_flag is cleared only by rst.
- LGS_RR_TIMEOUT_EN undefined:
  - hcnt and the timeout logic are removed.
  - A grant persists until ack, ovr or withdrawal.
  - to_flag is tied to 0 and HOLD_CYC is ignored.

## Test plan
- Reset, then idle check: drive req=0, pass=1, ovr=0. After 2 cycles idle=1, gnt=0 and to_flag=0.
- Round-robin: NREQ=7, req=7'b1000101 held, ack pulsed one cycle after each grant. Grant order is bits 0, 2, 6, 0, with one gnt=0 cycle between grants.
- Override: mid-grant on bit 2, pulse ovr=1 together with ack=1. gnt=0 next cycle and the next grant is again bit 2 (ptr unchanged). ch_a and ch_b read 0 for that cycle.
- Channel gating: ch_en=2'b10, src_a=1, src_b=0, ovr=0 -> one cycle later ch_a=2'b10, ch_b=2'b00. Raising ovr=1 -> ch_a=2'b00 one cycle later.
- Timeout (with LGS_RR_TIMEOUT_EN, HOLD_CYC=4): req=7'b0000010 held, no ack.
  - gnt=7'b0000010 for exactly 4 cycles.
  - Then one idle cycle with to_flag=1, then a re-grant of bit 1.
  - Without the macro, gnt stays high for 100 cycles and to_flag stays 0.
- Reset mid-grant: rst=1 while gnt=7'b0100000. All outputs read 0 on the next edge, and after release the first grant scan starts from bit 0.

Source files
------------

// File: rtl/lgs_rr_ctrl.sv
// Round-robin request arbiter with override-gated channel status; optional grant timeout via LGS_RR_TIMEOUT_EN.
// Latency: grant 1 cycle after sampled request, release 1 cycle after ack/ovr/withdrawal; ch_a/ch_b/idle lag inputs 1 cycle.
// Backpressure: pass=0 or ovr=1 holds off new grants; a grant is held until ack, ovr, withdrawal or timeout.
module lgs_rr_ctrl #(
    parameter int NREQ     = 7,
    parameter int NCH      = 2,
    parameter int HOLD_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            pass,
    input  logic            ovr,
    input  logic            ack,
    input  logic [NCH-1:0]  ch_en,
    input  logic            src_a,
    input  logic            src_b,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_vld,
    output logic            idle,
    output logic [NCH-1:0]  ch_a,
    output logic [NCH-1:0]  ch_b,
    output logic            to_flag
);

    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   gidx_inc;
    logic [PW-1:0]   sel_idx;
    logic            sel_found;
    logic            idle_q, idle_d;
    logic [NCH-1:0]  ch_a_q, ch_a_d;
    logic [NCH-1:0]  ch_b_q, ch_b_d;

`ifdef LGS_RR_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_CYC);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_CYC - 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          to_flag_q, to_flag_d;
    logic          hold_done;

    assign hold_done = (hcnt_q == HMAX);
`else
    logic unused_hold_cyc;
    assign unused_hold_cyc = (HOLD_CYC > 0);
`endif

    // First set request at or above ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[PW-1:0];
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_comb begin
        gidx_inc = '0;
        if (gidx_q != LAST_IDX) begin
            gidx_inc = gidx_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
`ifdef LGS_RR_TIMEOUT_EN
        hcnt_d    = hcnt_q;
        to_flag_d = to_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pass && !ovr && sel_found) begin
                    gidx_d  = sel_idx;
                    state_d = S_GRANT;
`ifdef LGS_RR_TIMEOUT_EN
                    hcnt_d  = '0;
`endif
                end
            end
            S_GRANT: begin
                if (ovr) begin
                    state_d = S_IDLE;
                end else if (ack) begin
                    state_d = S_IDLE;
                    ptr_d   = gidx_inc;
                end else if (!req[gidx_q]) begin
                    state_d = S_IDLE;
                end
`ifdef LGS_RR_TIMEOUT_EN
                else if (hold_done) begin
                    state_d   = S_IDLE;
                    ptr_d     = gidx_inc;
                    to_flag_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        idle_d = (req == '0) && pass;
        ch_a_d = ch_en & {NCH{~ovr & src_a}};
        ch_b_d = ch_en & {NCH{~ovr & src_b}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            idle_q    <= 1'b0;
            ch_a_q    <= '0;
            ch_b_q    <= '0;
`ifdef LGS_RR_TIMEOUT_EN
            hcnt_q    <= '0;
            to_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            idle_q    <= idle_d;
            ch_a_q    <= ch_a_d;
            ch_b_q    <= ch_b_d;
`ifdef LGS_RR_TIMEOUT_EN
            hcnt_q    <= hcnt_d;
            to_flag_q <= to_flag_d;
`endif
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == S_GRANT) begin
            gnt[gidx_q] = 1'b1;
        end
    end

    assign gnt_vld = (state_q == S_GRANT);
    assign idle    = idle_q;
    assign ch_a    = ch_a_q;
    assign ch_b    = ch_b_q;
`ifdef LGS_RR_TIMEOUT_EN
    assign to_flag = to_flag_q;
`else
    assign to_flag = 1'b0;
`endif

endmodule

// File: tb/tb_lgs_rr_ctrl.sv
// Directed bench for lgs_rr_ctrl: reset, round-robin order, override abort, channel gating, timeout and reset mid-grant.
module tb_lgs_rr_ctrl;

    localparam int NREQ     = 7;
    localparam int NCH      = 2;
    localparam int HOLD_CYC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            pass;
    logic            ovr;
    logic            ack;
    logic [NCH-1:0]  ch_en;
    logic            src_a;
    logic            src_b;
    logic [NREQ-1:0] gnt;
    logic            gnt_vld;
    logic            idle;
    logic [NCH-1:0]  ch_a;
    logic [NCH-1:0]  ch_b;
    logic            to_flag;

    int errors = 0;
    int checks = 0;

    lgs_rr_ctrl #(
        .NREQ     (NREQ),
        .NCH      (NCH),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .pass    (pass),
        .ovr     (ovr),
        .ack     (ack),
        .ch_en   (ch_en),
        .src_a   (src_a),
        .src_b   (src_b),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .idle    (idle),
        .ch_a    (ch_a),
        .ch_b    (ch_b),
        .to_flag (to_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        pass  = 1'b0;
        ovr   = 1'b0;
        ack   = 1'b0;
        ch_en = '0;
        src_a = 1'b0;
        src_b = 1'b0;
        tick();
        tick();
        chk("rst_gnt",     32'(gnt),     32'h0);
        chk("rst_gnt_vld", 32'(gnt_vld), 32'h0);
        chk("rst_idle",    32'(idle),    32'h0);
        chk("rst_ch_a",    32'(ch_a),    32'h0);
        chk("rst_ch_b",    32'(ch_b),    32'h0);
        chk("rst_to_flag", 32'(to_flag), 32'h0);

        // Idle detection after reset release
        rst  = 1'b0;
        pass = 1'b1;
        tick();
        tick();
        chk("idle_idle",    32'(idle),    32'h1);
        chk("idle_gnt",     32'(gnt),     32'h0);
        chk("idle_to_flag", 32'(to_flag), 32'h0);

        // Round-robin 0 -> 2 -> 6 -> 0 -> 2 with ack one cycle after each grant
        req   = 7'b1000101;
        ch_en = 2'b11;
        src_a = 1'b1;
        src_b = 1'b1;
        tick();
        chk("rr_g0",      32'(gnt),     32'h01);
        chk("rr_g0_vld",  32'(gnt_vld), 32'h1);
        chk("rr_g0_idle", 32'(idle),    32'h0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("rr_gap0", 32'(gnt), 32'h0);
        chk("rr_gap0_vld", 32'(gnt_vld), 32'h0);
        tick();
        chk("rr_g2", 32'(gnt), 32'h04);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("rr_gap1", 32'(gnt), 32'h0);
        tick();
        chk("rr_g6", 32'(gnt), 32'h40);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("rr_gap2", 32'(gnt), 32'h0);
        tick();
        chk("rr_wrap_g0", 32'(gnt), 32'h01);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("ovr_pre_g2", 32'(gnt), 32'h04);

        // Override together with ack: abort, ptr stays, channels masked
        ovr = 1'b1;
        ack = 1'b1;
        tick();
        ovr = 1'b0;
        ack = 1'b0;
        chk("ovr_gnt",  32'(gnt),  32'h0);
        chk("ovr_ch_a", 32'(ch_a), 32'h0);
        chk("ovr_ch_b", 32'(ch_b), 32'h0);
        tick();
        chk("ovr_regrant_g2", 32'(gnt),  32'h04);
        chk("ovr_ch_a_back",  32'(ch_a), 32'h3);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Channel gating; ptr is now 3
        req   = '0;
        ch_en = 2'b10;
        src_a = 1'b1;
        src_b = 1'b0;
        tick();
        chk("chg_ch_a", 32'(ch_a), 32'h2);
        chk("chg_ch_b", 32'(ch_b), 32'h0);
        chk("chg_idle", 32'(idle), 32'h1);
        ovr = 1'b1;
        tick();
        ovr = 1'b0;
        chk("chg_ovr_ch_a", 32'(ch_a), 32'h0);
        pass = 1'b0;
        tick();
        chk("pass0_idle", 32'(idle), 32'h0);
        pass = 1'b1;

        // Single requester held without ack
        req = 7'b0000010;
`ifdef LGS_RR_TIMEOUT_EN
        for (int k = 0; k < HOLD_CYC; k++) begin
            tick();
            chk($sformatf("to_hold_%0d", k), 32'(gnt), 32'h02);
        end
        tick();
        chk("to_gap_gnt",  32'(gnt),     32'h0);
        chk("to_gap_flag", 32'(to_flag), 32'h1);
        tick();
        chk("to_regrant",      32'(gnt),     32'h02);
        chk("to_flag_sticky",  32'(to_flag), 32'h1);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            chk($sformatf("hold_%0d", k), 32'(gnt), 32'h02);
        end
        chk("hold_to_flag", 32'(to_flag), 32'h0);
`endif
        req = '0;
        tick();
        chk("withdraw_gnt", 32'(gnt), 32'h0);

        // Reset mid-grant, then scan restarts from bit 0
        ch_en = 2'b11;
        src_a = 1'b1;
        src_b = 1'b1;
        req   = 7'b0100000;
        tick();
        chk("mid_g5", 32'(gnt), 32'h20);
        rst = 1'b1;
        req = 7'b0100001;
        tick();
        rst = 1'b0;
        chk("mid_rst_gnt",     32'(gnt),     32'h0);
        chk("mid_rst_gnt_vld", 32'(gnt_vld), 32'h0);
        chk("mid_rst_idle",    32'(idle),    32'h0);
        chk("mid_rst_ch_a",    32'(ch_a),    32'h0);
        chk("mid_rst_ch_b",    32'(ch_b),    32'h0);
        chk("mid_rst_to_flag", 32'(to_flag), 32'h0);
        tick();
        chk("post_rst_g0", 32'(gnt), 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
